// File: rtl/chesstypes.sv
// Shared chess type definitions: piece/colour encodings and the board-square record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chesstypes;

    localparam int NSQUARES = 64;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_t;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } color_t;

    typedef struct packed {
        color_t color;
        piece_t piece;
    } fullpiece_t;

endpackage

// File: rtl/king_square_match.sv
// Flags a square holding the king of a given colour; shared with the king-on-square check.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module king_square_match
    import chesstypes::*;
(
    input  fullpiece_t sq,
    input  color_t     c,
    output logic       match
);

    // A match needs both the piece type and the owning colour to agree
    always_comb begin
        match = (sq.piece == KING) && (sq.color == c);
    end

endmodule

// File: rtl/king_locator.sv
// Scans the board one square per cycle for the king of the requested colour.
// Latency: fixed 65 cycles from accepted start to done, no early exit.
// Backpressure: start is only accepted while busy is low; starts during a scan are dropped.
module king_locator
    import chesstypes::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  fullpiece_t [NSQUARES-1:0] board,
    input  color_t                    playing,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      result_valid,
    output logic [5:0]                king_pos,
    output logic                      found,
    output logic                      multiple
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NSQUARES - 1);

    state_t     state;
    state_t     state_nxt;

    // Scan bookkeeping
    logic [5:0] idx;
    logic [5:0] idx_d;
    color_t     playing_q;
    color_t     playing_q_d;

    // Working registers: position of the first hit and a saturating hit count (0, 1, 2+)
    logic [5:0] first_pos_w;
    logic [5:0] first_pos_d;
    logic [1:0] count_w;
    logic [1:0] count_d;

    // Next values of the registered outputs
    logic       busy_d;
    logic       done_d;
    logic       result_valid_d;
    logic [5:0] king_pos_d;
    logic       found_d;
    logic       multiple_d;

    logic       sq_match;
    logic       last_sq;

    king_square_match u_match (
        .sq    (board[idx]),
        .c     (playing_q),
        .match (sq_match)
    );

    assign last_sq = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: REPORT behaves like IDLE for an incoming start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last_sq) state_nxt = REPORT;
            REPORT:  state_nxt = start ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values; everything is registered below so outputs are glitch-free
    always_comb begin
        idx_d          = idx;
        playing_q_d    = playing_q;
        first_pos_d    = first_pos_w;
        count_d        = count_w;
        done_d         = 1'b0;
        result_valid_d = result_valid;
        king_pos_d     = king_pos;
        found_d        = found;
        multiple_d     = multiple;

        case (state)
            IDLE, REPORT: begin
                if (start) begin
                    // Previous results stay visible; only their valid flag drops
                    playing_q_d    = playing;
                    idx_d          = '0;
                    first_pos_d    = '0;
                    count_d        = '0;
                    result_valid_d = 1'b0;
                end
            end
            SCAN: begin
                idx_d = idx + 6'd1;
                if (sq_match) begin
                    if (count_w == 2'd0) begin
                        first_pos_d = idx;
                    end
                    if (count_w != 2'd2) begin
                        count_d = count_w + 2'd1;
                    end
                end
                // The final square's contribution is folded in before publishing
                if (last_sq) begin
                    done_d         = 1'b1;
                    result_valid_d = 1'b1;
                    king_pos_d     = first_pos_d;
                    found_d        = (count_d != 2'd0);
                    multiple_d     = (count_d == 2'd2);
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase

        busy_d = (state_nxt == SCAN);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            playing_q    <= WHITE;
            first_pos_w  <= '0;
            count_w      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            king_pos     <= '0;
            found        <= 1'b0;
            multiple     <= 1'b0;
        end else begin
            idx          <= idx_d;
            playing_q    <= playing_q_d;
            first_pos_w  <= first_pos_d;
            count_w      <= count_d;
            busy         <= busy_d;
            done         <= done_d;
            result_valid <= result_valid_d;
            king_pos     <= king_pos_d;
            found        <= found_d;
            multiple     <= multiple_d;
        end
    end

endmodule

// File: tb/tb_king_locator.sv
// Self-checking bench for king_locator: directed vectors, timing corner cases, random boards.
// Latency: checks the fixed 65-cycle start-to-done timing.
// Backpressure: exercises ignored starts while busy and back-to-back starts in REPORT.
module tb_king_locator;
    import chesstypes::*;

    logic                      clk;
    logic                      rst;
    fullpiece_t [NSQUARES-1:0] board;
    color_t                    playing;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      result_valid;
    logic [5:0]                king_pos;
    logic                      found;
    logic                      multiple;

    int checks = 0;
    int errors = 0;

    king_locator dut (
        .clk          (clk),
        .rst          (rst),
        .board        (board),
        .playing      (playing),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .king_pos     (king_pos),
        .found        (found),
        .multiple     (multiple)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        fullpiece_t [NSQUARES-1:0] b;
        color_t                    c;
        logic [5:0]                exp_pos;
        logic                      exp_found;
        logic                      exp_mult;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic fullpiece_t [NSQUARES-1:0] empty_board();
        fullpiece_t [NSQUARES-1:0] b;
        for (int i = 0; i < NSQUARES; i++) begin
            b[i].color = WHITE;
            b[i].piece = EMPTY;
        end
        return b;
    endfunction

    function automatic fullpiece_t mk(input color_t c, input piece_t p);
        fullpiece_t f;
        f.color = c;
        f.piece = p;
        return f;
    endfunction

    // Runs one scan starting at the current negedge (cycle 0). Extra start pulses are
    // driven in cycles s1/s2, reset is pulsed in cycle rst_cyc. Outputs are sampled at
    // each negedge, i.e. in the middle of cycle cyc.
    task automatic run(input fullpiece_t [NSQUARES-1:0] b, input color_t c,
                       input int s1, input int s2, input int rst_cyc, input int horizon,
                       output int first_done, output int last_done, output int ndone);
        logic [5:0] prev_pos;
        logic       prev_found;
        logic       prev_mult;
        prev_pos   = king_pos;
        prev_found = found;
        prev_mult  = multiple;
        board      = b;
        playing    = c;
        start      = 1'b1;
        first_done = -1;
        last_done  = -1;
        ndone      = 0;
        for (int cyc = 1; cyc <= horizon; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = cyc;
                last_done = cyc;
            end
            if (rst_cyc < 0) begin
                if (cyc == 1) begin
                    chk("busy_cycle1", busy, 1);
                    chk("rv_dropped_cycle1", result_valid, 0);
                end
                if (cyc == 64) begin
                    chk("busy_cycle64", busy, 1);
                    chk("pos_stable_during_scan", king_pos, prev_pos);
                    chk("found_stable_during_scan", found, prev_found);
                    chk("mult_stable_during_scan", multiple, prev_mult);
                end
                if (cyc == 65) begin
                    chk("busy_cycle65", busy, 0);
                    chk("rv_cycle65", result_valid, 1);
                end
            end
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rv", result_valid, 0);
                chk("rst_pos", king_pos, 0);
                chk("rst_found", found, 0);
                chk("rst_mult", multiple, 0);
            end
            if (cyc == rst_cyc + 1) rst = 1'b0;
            start = (cyc == s1) || (cyc == s2);
        end
        start = 1'b0;
    endtask

    vec_t                      vecs[7];
    fullpiece_t [NSQUARES-1:0] b;
    int                        fd, ld, nd;
    int                        wp, bp;
    logic [5:0]                exp_pos;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        playing = WHITE;
        board   = empty_board();
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rv", result_valid, 0);
        chk("reset_pos", king_pos, 0);
        chk("reset_found", found, 0);
        chk("reset_mult", multiple, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors: expected values derived by hand from the placement of kings
        vecs[0].b = empty_board(); vecs[0].c = WHITE;
        vecs[0].exp_pos = 6'd0; vecs[0].exp_found = 0; vecs[0].exp_mult = 0;

        b = empty_board(); b[4] = mk(WHITE, KING); b[60] = mk(BLACK, KING);
        b[5] = mk(BLACK, QUEEN); b[59] = mk(WHITE, ROOK);
        vecs[1].b = b; vecs[1].c = BLACK;
        vecs[1].exp_pos = 6'd60; vecs[1].exp_found = 1; vecs[1].exp_mult = 0;
        vecs[2].b = b; vecs[2].c = WHITE;
        vecs[2].exp_pos = 6'd4; vecs[2].exp_found = 1; vecs[2].exp_mult = 0;

        b = empty_board(); b[10] = mk(WHITE, KING); b[50] = mk(WHITE, KING);
        vecs[3].b = b; vecs[3].c = WHITE;
        vecs[3].exp_pos = 6'd10; vecs[3].exp_found = 1; vecs[3].exp_mult = 1;
        vecs[4].b = b; vecs[4].c = BLACK;
        vecs[4].exp_pos = 6'd0; vecs[4].exp_found = 0; vecs[4].exp_mult = 0;

        b = empty_board(); b[0] = mk(WHITE, KING); b[63] = mk(WHITE, KING);
        vecs[5].b = b; vecs[5].c = WHITE;
        vecs[5].exp_pos = 6'd0; vecs[5].exp_found = 1; vecs[5].exp_mult = 1;

        b = empty_board(); b[7] = mk(BLACK, KING); b[20] = mk(BLACK, KING);
        b[40] = mk(BLACK, KING); b[3] = mk(WHITE, KING);
        vecs[6].b = b; vecs[6].c = BLACK;
        vecs[6].exp_pos = 6'd7; vecs[6].exp_found = 1; vecs[6].exp_mult = 1;

        for (int v = 0; v < 7; v++) begin
            run(vecs[v].b, vecs[v].c, -1, -1, -1, 66, fd, ld, nd);
            chk($sformatf("vec%0d_latency", v), fd, 65);
            chk($sformatf("vec%0d_ndone", v), nd, 1);
            chk($sformatf("vec%0d_pos", v), king_pos, vecs[v].exp_pos);
            chk($sformatf("vec%0d_found", v), found, vecs[v].exp_found);
            chk($sformatf("vec%0d_mult", v), multiple, vecs[v].exp_mult);
            chk($sformatf("vec%0d_rv_hold", v), result_valid, 1);
        end

        // Starts while busy are dropped: exactly one done, at cycle 65
        b = empty_board(); b[33] = mk(BLACK, KING);
        run(b, BLACK, 5, 30, -1, 140, fd, ld, nd);
        chk("ignored_start_latency", fd, 65);
        chk("ignored_start_ndone", nd, 1);
        chk("ignored_start_pos", king_pos, 33);

        // Start in the REPORT cycle is accepted: second done at cycle 130
        b = empty_board(); b[4] = mk(WHITE, KING);
        run(b, WHITE, 65, -1, -1, 131, fd, ld, nd);
        chk("b2b_first_done", fd, 65);
        chk("b2b_second_done", ld, 130);
        chk("b2b_ndone", nd, 2);
        chk("b2b_pos", king_pos, 4);

        // Reset in cycle 20 aborts the scan with no done
        b = empty_board(); b[12] = mk(WHITE, KING);
        run(b, WHITE, -1, -1, 20, 100, fd, ld, nd);
        chk("abort_ndone", nd, 0);
        chk("abort_rv", result_valid, 0);
        run(b, WHITE, -1, -1, -1, 66, fd, ld, nd);
        chk("after_reset_latency", fd, 65);
        chk("after_reset_pos", king_pos, 12);
        chk("after_reset_found", found, 1);

        // Random boards, one king per colour, scanned back-to-back via start in REPORT
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < NSQUARES; i++) begin
                b[i] = mk(color_t'($urandom_range(0, 1)), piece_t'($urandom_range(0, 5)));
            end
            wp = $urandom_range(0, 63);
            bp = $urandom_range(0, 62);
            if (bp >= wp) bp++;
            b[wp] = mk(WHITE, KING);
            b[bp] = mk(BLACK, KING);
            exp_pos = (n % 2 == 0) ? 6'(wp) : 6'(bp);
            run(b, (n % 2 == 0) ? WHITE : BLACK, -1, -1, -1, 65, fd, ld, nd);
            chk($sformatf("rand%0d_latency", n), fd, 65);
            chk($sformatf("rand%0d_pos", n), king_pos, exp_pos);
            chk($sformatf("rand%0d_found", n), found, 1);
            chk($sformatf("rand%0d_mult", n), multiple, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
